// File: rtl/spi_shift_engine_if.sv
// Signal bundle between the SPI controller (FIFOs, configuration) and spi_shift_engine.
// The engine takes the slave modport. The controller or testbench takes the master modport.
interface spi_shift_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int DIV_WIDTH  = 8
) ();
  logic [DIV_WIDTH-1:0]  clk_div_i;
  logic                  quad_i;
  logic                  rx_dir_i;
  logic [CNT_WIDTH-1:0]  len_i;
  logic                  start_i;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  spi_clk_o;
  logic [3:0]            sdo_o;
  logic [3:0]            oe_o;
  logic [3:0]            sdi_i;

  modport slave (
    input  clk_div_i, quad_i, rx_dir_i, len_i, start_i, tx_data_i, tx_valid_i,
           rx_ready_i, sdi_i,
    output tx_ready_o, rx_data_o, rx_valid_o, busy_o, done_o, spi_clk_o, sdo_o, oe_o
  );

  modport master (
    output clk_div_i, quad_i, rx_dir_i, len_i, start_i, tx_data_i, tx_valid_i,
           rx_ready_i, sdi_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, busy_o, done_o, spi_clk_o, sdo_o, oe_o
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI bit engine: generates SCK (CPOL=0, CPHA=0) and serialises/deserialises FIFO words.
// It supports standard full-duplex mode and quad half-duplex mode.
module spi_shift_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int DIV_WIDTH  = 8
) (
  input logic               HCLK,
  input logic               HRESETn,
  spi_shift_engine_if.slave bus
);
  localparam int WBW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STALL, S_DONE} state_t;

  state_t                r_state;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [CNT_WIDTH-1:0]  r_bits_left;
  logic [WBW-1:0]        r_wbits;
  logic                  r_quad;
  logic                  r_rx_dir;
  logic                  r_sck;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [DATA_WIDTH-1:0] r_rx_sh;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_tx_ready;
  logic                  r_busy;
  logic                  r_done;
  logic [3:0]            r_sdo;
  logic [3:0]            r_oe;

  logic [CNT_WIDTH-1:0]  w_len;
  logic [WBW-1:0]        w_step;
  logic [CNT_WIDTH-1:0]  w_bits_next;
  logic [DATA_WIDTH-1:0] w_rx_shifted;
  logic [DATA_WIDTH-1:0] w_tx_shifted;
  logic                  w_tick;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_word_end;
  logic                  w_rx_free;
  logic                  w_word_out;

  function automatic logic [3:0] lead_bits(input logic [DATA_WIDTH-1:0] word,
                                           input logic quad, input logic rx_dir);
    if (!quad) return {3'b000, word[DATA_WIDTH-1]};
    if (rx_dir) return 4'b0000;
    return word[DATA_WIDTH-1 -: 4];
  endfunction

  function automatic logic [3:0] oe_pattern(input logic quad, input logic rx_dir);
    if (!quad) return 4'b0001;
    return rx_dir ? 4'b0000 : 4'b1111;
  endfunction

  // Quad transfers move whole nibbles, so the two low length bits are dropped.
  assign w_len        = bus.quad_i ? {bus.len_i[CNT_WIDTH-1:2], 2'b00} : bus.len_i;
  assign w_step       = r_quad ? WBW'(4) : WBW'(1);
  assign w_bits_next  = (r_bits_left > CNT_WIDTH'(w_step)) ? r_bits_left - CNT_WIDTH'(w_step) : '0;
  assign w_tick       = (r_state == S_SHIFT) && (r_div_cnt == r_div);
  assign w_rise       = w_tick && !r_sck;
  assign w_fall       = w_tick && r_sck;
  assign w_word_end   = (r_wbits == WBW'(DATA_WIDTH)) || (r_bits_left == '0);
  assign w_rx_free    = !r_rx_valid || bus.rx_ready_i;
  assign w_word_out   = w_rx_free && ((w_fall && w_word_end) || (r_state == S_STALL));
  assign w_tx_shifted = r_quad ? (r_tx_sh << 4) : (r_tx_sh << 1);

  // Quad transmit ignores the SDI pads, so its RX words are all zeros.
  always_comb begin
    // NOTE: default first so no path leaves w_rx_shifted unassigned and infers a latch.
    w_rx_shifted = {r_rx_sh[DATA_WIDTH-2:0], bus.sdi_i[1]};
    if (r_quad) w_rx_shifted = {r_rx_sh[DATA_WIDTH-5:0], r_rx_dir ? bus.sdi_i : 4'b0000};
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_bits_left <= '0;
      r_wbits     <= '0;
      r_quad      <= 1'b0;
      r_rx_dir    <= 1'b0;
      r_sck       <= 1'b0;
      r_tx_sh     <= '0;
      r_rx_sh     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sdo       <= '0;
      r_oe        <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_rx_valid && bus.rx_ready_i) r_rx_valid <= 1'b0;

      unique case (r_state)
        S_IDLE: if (bus.start_i) begin
          r_quad      <= bus.quad_i;
          r_rx_dir    <= bus.rx_dir_i;
          r_div       <= bus.clk_div_i;
          r_bits_left <= w_len;
          if (w_len == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_tx_ready <= 1'b1;
            r_oe       <= oe_pattern(bus.quad_i, bus.rx_dir_i);
          end
        end
        S_LOAD: if (bus.tx_valid_i) begin
          r_tx_ready <= 1'b0;
          r_tx_sh    <= bus.tx_data_i;
          r_sdo      <= lead_bits(bus.tx_data_i, r_quad, r_rx_dir);
          r_rx_sh    <= '0;
          r_wbits    <= '0;
          r_div_cnt  <= '0;
          r_state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
          if (w_rise) begin
            r_rx_sh     <= w_rx_shifted;
            r_bits_left <= w_bits_next;
            r_wbits     <= r_wbits + w_step;
          end
          if (w_fall && !w_word_end) begin
            r_tx_sh <= w_tx_shifted;
            r_sdo   <= lead_bits(w_tx_shifted, r_quad, r_rx_dir);
          end
          if (w_fall && w_word_end && !w_rx_free) r_state <= S_STALL;
        end
        S_STALL: begin
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_oe    <= '0;
          r_sdo   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase

      // A completed word (fresh, or parked in STALL) moves to the RX port and picks the next state.
      if (w_word_out) begin
        r_rx_data  <= r_rx_sh;
        r_rx_valid <= 1'b1;
        if (r_bits_left != '0) begin
          r_state    <= S_LOAD;
          r_tx_ready <= 1'b1;
        end else begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign bus.tx_ready_o = r_tx_ready;
  assign bus.rx_data_o  = r_rx_data;
  assign bus.rx_valid_o = r_rx_valid;
  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  assign bus.spi_clk_o  = r_sck;
  assign bus.sdo_o      = r_sdo;
  assign bus.oe_o       = r_oe;
endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: stimulus pushes expected SDO beats and RX words.
// Independent monitors pop those expectations when the DUT presents them.
module tb_spi_shift_engine;
  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  spi_shift_engine_if bus ();
  spi_shift_engine dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus.slave));

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic [3:0]  sdo_q[$];

  logic       loop_en = 1'b1;
  logic [3:0] tb_sdi  = 4'h0;
  assign bus.sdi_i = loop_en ? {2'b00, bus.sdo_o[0], 1'b0} : tb_sdi;

  int       exp_half = 1;
  logic [3:0] exp_oe = 4'b0001;
  int sck_rises = 0, done_cnt = 0, tx_hs = 0, load_wait = 0, load_sck_hi = 0, busy_gap = 0;
  int tx_gap = 0, gap_left = 0, d0 = 0, h0 = 0;
  logic busy_at_done = 1'b0;
  bit   in_xfer = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // TX FIFO model: presents the queue head and optionally withholds data while the engine waits.
  initial begin : tx_drv
    bit hs;
    forever begin
      @(negedge HCLK);
      hs = bus.tx_valid_i && bus.tx_ready_o;
      if (!bus.tx_valid_i && bus.tx_ready_o) begin
        load_wait++;
        if (bus.spi_clk_o) load_sck_hi++;
        if (gap_left > 0) gap_left--;
      end
      @(posedge HCLK); #1;
      if (hs && tx_q.size() > 0) begin
        void'(tx_q.pop_front());
        tx_hs++;
        gap_left = tx_gap;
      end
      bus.tx_valid_i = (gap_left == 0) && (tx_q.size() > 0);
      bus.tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
    end
  end

  initial begin : sck_mon
    logic prev = 1'b0;
    int   high_len = 0;
    logic [3:0] e;
    forever begin
      @(negedge HCLK);
      if (bus.spi_clk_o && !prev) begin
        sck_rises++;
        high_len = 1;
        if (sdo_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sdo_extra: unexpected SCK rise with sdo=0x%0h", bus.sdo_o);
        end else begin
          e = sdo_q.pop_front();
          check("sdo", bus.sdo_o, e);
        end
        check("oe", bus.oe_o, exp_oe);
      end else if (bus.spi_clk_o) begin
        high_len++;
      end else if (prev && HRESETn) begin
        check("sck_high_len", high_len, exp_half);
      end
      prev = bus.spi_clk_o;
    end
  end

  initial begin : rx_mon
    logic [31:0] e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && bus.rx_valid_o && bus.rx_ready_i) begin
        if (rx_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rx_extra: unexpected word 0x%0h", bus.rx_data_o);
        end else begin
          e = rx_q.pop_front();
          check("rx_data", bus.rx_data_o, e);
        end
      end
    end
  end

  initial begin : status_mon
    forever begin
      @(negedge HCLK);
      if (bus.done_o) begin
        done_cnt++;
        busy_at_done = bus.busy_o;
      end
      if (in_xfer && !bus.done_o && !bus.busy_o) busy_gap++;
    end
  end

  task automatic push_std_bits(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) sdo_q.push_back({3'b000, w[31-i]});
  endtask

  task automatic start_xfer(input logic quad, input logic rx_dir, input logic [7:0] div,
                            input logic [15:0] len);
    exp_half = int'(div) + 1;
    exp_oe   = !quad ? 4'b0001 : (rx_dir ? 4'b0000 : 4'b1111);
    busy_gap = 0;
    d0 = done_cnt;
    h0 = tx_hs;
    repeat (2) @(posedge HCLK);
    #1;
    bus.quad_i    = quad;
    bus.rx_dir_i  = rx_dir;
    bus.clk_div_i = div;
    bus.len_i     = len;
    bus.start_i   = 1'b1;
    @(posedge HCLK); #1;
    bus.start_i   = 1'b0;
    // Scramble the configuration after start: the engine must keep its latched copy.
    bus.quad_i    = ~quad;
    bus.rx_dir_i  = ~rx_dir;
    bus.clk_div_i = ~div;
    bus.len_i     = 16'hFFFF;
    in_xfer = 1'b1;
  endtask

  task automatic finish_xfer(input string name, input int hs_exp);
    int c = 0;
    while (done_cnt == d0 && c < 5000) begin
      @(posedge HCLK); #1;
      c++;
    end
    in_xfer = 1'b0;
    repeat (4) @(posedge HCLK);
    #1;
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_busy_at_done"}, busy_at_done, 0);
    check({name, "_tx_handshakes"}, tx_hs - h0, hs_exp);
    check({name, "_rx_left"}, rx_q.size(), 0);
    check({name, "_sdo_left"}, sdo_q.size(), 0);
    check({name, "_busy_gap"}, busy_gap, 0);
    check({name, "_idle_pads"}, {bus.spi_clk_o, bus.oe_o, bus.busy_o}, 0);
  endtask

  initial begin : stim
    int r;
    int c;
    HRESETn        = 1'b0;
    bus.clk_div_i  = '0;
    bus.quad_i     = 1'b0;
    bus.rx_dir_i   = 1'b0;
    bus.len_i      = '0;
    bus.start_i    = 1'b0;
    bus.tx_data_i  = '0;
    bus.tx_valid_i = 1'b0;
    bus.rx_ready_i = 1'b1;
    #23;
    check("reset_outputs", {bus.tx_ready_o, bus.rx_data_o, bus.rx_valid_o, bus.busy_o,
                            bus.done_o, bus.spi_clk_o, bus.sdo_o, bus.oe_o}, 0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Standard mode, 8 bits, loopback: SDO 1,0,1,0,0,1,0,1 and RX word 0xA5.
    loop_en = 1'b1;
    tx_q.push_back(32'hA500_0000);
    rx_q.push_back(32'h0000_00A5);
    foreach (sdo_q[i]) sdo_q.delete(i);
    sdo_q.push_back(4'h1); sdo_q.push_back(4'h0); sdo_q.push_back(4'h1); sdo_q.push_back(4'h0);
    sdo_q.push_back(4'h0); sdo_q.push_back(4'h1); sdo_q.push_back(4'h0); sdo_q.push_back(4'h1);
    start_xfer(1'b0, 1'b0, 8'd0, 16'd8);
    finish_xfer("std8", 1);

    // Standard mode, two full words, half-period of 4 HCLK cycles.
    tx_q.push_back(32'hDEAD_BEEF); tx_q.push_back(32'h0123_CAFE);
    rx_q.push_back(32'hDEAD_BEEF); rx_q.push_back(32'h0123_CAFE);
    push_std_bits(32'hDEAD_BEEF, 32); push_std_bits(32'h0123_CAFE, 32);
    start_xfer(1'b0, 1'b0, 8'd3, 16'd64);
    finish_xfer("std64", 2);

    // Quad transmit: nibbles 1..8 on all four pads. The SDI pads are driven but must be ignored.
    loop_en = 1'b0;
    tb_sdi  = 4'hF;
    tx_q.push_back(32'h1234_5678);
    rx_q.push_back(32'h0000_0000);
    for (int i = 1; i <= 8; i++) sdo_q.push_back(4'(i));
    start_xfer(1'b1, 1'b0, 8'd1, 16'd32);
    finish_xfer("quad_tx", 1);

    // Quad receive: a length of 10 is truncated to 8, giving two 0xC nibbles. The TX word is discarded.
    tb_sdi = 4'hC;
    tx_q.push_back(32'hFFFF_FFFF);
    rx_q.push_back(32'h0000_00CC);
    sdo_q.push_back(4'h0); sdo_q.push_back(4'h0);
    start_xfer(1'b1, 1'b1, 8'd2, 16'd10);
    finish_xfer("quad_rx", 1);

    // RX back-pressure: the second word boundary parks in STALL until the first word drains.
    loop_en = 1'b1;
    bus.rx_ready_i = 1'b0;
    tx_q.push_back(32'h5A5A_0F0F); tx_q.push_back(32'hC3C3_9696);
    rx_q.push_back(32'h5A5A_0F0F); rx_q.push_back(32'hC3C3_9696);
    push_std_bits(32'h5A5A_0F0F, 32); push_std_bits(32'hC3C3_9696, 32);
    start_xfer(1'b0, 1'b0, 8'd1, 16'd64);
    c = 0;
    while (!bus.rx_valid_o && c < 1000) begin
      @(posedge HCLK); #1;
      c++;
    end
    check("stall_first_word_seen", bus.rx_valid_o, 1);
    repeat (200) @(posedge HCLK);
    #1;
    r = sck_rises;
    repeat (20) @(posedge HCLK);
    #1;
    check("stall_no_sck", sck_rises - r, 0);
    check("stall_sck_low", bus.spi_clk_o, 0);
    check("stall_busy", bus.busy_o, 1);
    bus.rx_ready_i = 1'b1;
    finish_xfer("stall", 2);

    // TX underrun: the second word is withheld for 10 cycles while the engine waits in LOAD.
    tx_gap = 10;
    gap_left = 0;
    tx_q.push_back(32'h8000_0001); tx_q.push_back(32'h7FFF_FFFE);
    rx_q.push_back(32'h8000_0001); rx_q.push_back(32'h7FFF_FFFE);
    push_std_bits(32'h8000_0001, 32); push_std_bits(32'h7FFF_FFFE, 32);
    r = load_wait;
    c = load_sck_hi;
    start_xfer(1'b0, 1'b0, 8'd0, 16'd64);
    finish_xfer("tx_gap", 2);
    check("tx_gap_load_wait", load_wait - r, 10);
    check("tx_gap_sck_low", load_sck_hi - c, 0);
    tx_gap = 0;
    gap_left = 0;

    // A zero-length transfer completes the cycle after start, with no SCK.
    r = sck_rises;
    d0 = done_cnt;
    @(posedge HCLK); #1;
    bus.quad_i = 1'b0;
    bus.len_i  = 16'd0;
    bus.start_i = 1'b1;
    @(posedge HCLK); #1;
    bus.start_i = 1'b0;
    check("len0_done_next_cycle", bus.done_o, 1);
    check("len0_busy", bus.busy_o, 0);
    @(posedge HCLK); #1;
    check("len0_done_width", bus.done_o, 0);
    repeat (3) @(posedge HCLK);
    #1;
    check("len0_no_sck", sck_rises - r, 0);
    check("len0_done_count", done_cnt - d0, 1);

    // Asynchronous reset mid-shift: outputs clear immediately and no done pulse follows.
    tx_q.push_back(32'hFACE_B00C); tx_q.push_back(32'h1111_2222);
    push_std_bits(32'hFACE_B00C, 32);
    r = sck_rises;
    start_xfer(1'b0, 1'b0, 8'd3, 16'd64);
    repeat (40) @(posedge HCLK);
    #1;
    check("rst_mid_active", {bus.busy_o, (sck_rises > r)}, 2'b11);
    #2;
    HRESETn = 1'b0;
    #1;
    check("rst_mid_outputs", {bus.tx_ready_o, bus.rx_data_o, bus.rx_valid_o, bus.busy_o,
                              bus.done_o, bus.spi_clk_o, bus.sdo_o, bus.oe_o}, 0);
    in_xfer = 1'b0;
    tx_q.delete();
    rx_q.delete();
    sdo_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (10) @(posedge HCLK);
    #1;
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle", {bus.busy_o, bus.spi_clk_o, bus.oe_o}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
